// File: rtl/ptw_walk_arbiter_if.sv
// Handshake bundle between the two TLB requesters, the shared page-table walker and the walk arbiter.
interface ptw_walk_arbiter_if #(
  parameter int XLEN = 32
);
  logic            if_miss_valid;
  logic [XLEN-1:0] if_miss_vaddr;
  logic            ex_miss_valid;
  logic [XLEN-1:0] ex_miss_vaddr;
  logic            ex_miss_is_store;
  logic            translation_enabled;
  logic            tlb_flush_all;
  logic            tlb_flush_vaddr;
  logic            ptw_req_valid;
  logic [XLEN-1:0] ptw_req_vaddr;
  logic            ptw_req_is_store;
  logic            ptw_req_is_fetch;
  logic            ptw_done;
  logic            ptw_page_fault;
  logic            ptw_result_valid;
  logic            itlb_update_valid;
  logic            dtlb_update_valid;
  logic            if_walk_done;
  logic            ex_walk_done;
  logic            if_walk_fault;
  logic            ex_walk_fault;
  logic            busy;

  modport slave (
    input  if_miss_valid, if_miss_vaddr, ex_miss_valid, ex_miss_vaddr, ex_miss_is_store,
           translation_enabled, tlb_flush_all, tlb_flush_vaddr,
           ptw_done, ptw_page_fault, ptw_result_valid,
    output ptw_req_valid, ptw_req_vaddr, ptw_req_is_store, ptw_req_is_fetch,
           itlb_update_valid, dtlb_update_valid, if_walk_done, ex_walk_done,
           if_walk_fault, ex_walk_fault, busy
  );

  modport master (
    output if_miss_valid, if_miss_vaddr, ex_miss_valid, ex_miss_vaddr, ex_miss_is_store,
           translation_enabled, tlb_flush_all, tlb_flush_vaddr,
           ptw_done, ptw_page_fault, ptw_result_valid,
    input  ptw_req_valid, ptw_req_vaddr, ptw_req_is_store, ptw_req_is_fetch,
           itlb_update_valid, dtlb_update_valid, if_walk_done, ex_walk_done,
           if_walk_fault, ex_walk_fault, busy
  );
endinterface

// File: rtl/ptw_walk_arbiter.sv
// Grants the shared page-table walker to the I-TLB or D-TLB, routes the result back and drops
// walks made stale by a flush or by translation being switched off.
module ptw_walk_arbiter #(
  parameter int XLEN         = 32,
  parameter int MAX_IF_DEFER = 4
) (
  input  logic              clk,
  input  logic              reset,
  ptw_walk_arbiter_if.slave bus
);
  localparam int CNT_W = (MAX_IF_DEFER < 1) ? 1 : $clog2(MAX_IF_DEFER + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_IF_DEFER);

  typedef enum logic [1:0] {IDLE, WALK_IF, WALK_EX} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] defer_cnt_q, defer_cnt_d;
  logic            stale_q, stale_d;
  logic            mask_if_q, mask_if_d;
  logic            mask_ex_q, mask_ex_d;
  logic [XLEN-1:0] vaddr_q, vaddr_d;
  logic            is_store_q, is_store_d;
  logic            is_fetch_q, is_fetch_d;

  logic if_elig, ex_elig, flush, keep;

  // A side that just completed is held off for one cycle so its done pulse can retire the miss.
  assign if_elig = bus.if_miss_valid && !mask_if_q;
  assign ex_elig = bus.ex_miss_valid && !mask_ex_q;
  assign flush   = bus.tlb_flush_all || bus.tlb_flush_vaddr;
  assign keep    = !stale_q && !flush;

  assign bus.ptw_req_valid    = (state_q != IDLE);
  assign bus.busy             = (state_q != IDLE);
  assign bus.ptw_req_vaddr    = vaddr_q;
  assign bus.ptw_req_is_store = is_store_q;
  assign bus.ptw_req_is_fetch = is_fetch_q;

  always_comb begin
    state_d               = state_q;
    defer_cnt_d           = defer_cnt_q;
    stale_d               = stale_q;
    mask_if_d             = 1'b0;
    mask_ex_d             = 1'b0;
    vaddr_d               = vaddr_q;
    is_store_d            = is_store_q;
    is_fetch_d            = is_fetch_q;
    bus.itlb_update_valid = 1'b0;
    bus.dtlb_update_valid = 1'b0;
    bus.if_walk_done      = 1'b0;
    bus.ex_walk_done      = 1'b0;
    bus.if_walk_fault     = 1'b0;
    bus.ex_walk_fault     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.translation_enabled) begin
          if (if_elig && (!ex_elig || defer_cnt_q == CNT_MAX)) begin
            state_d     = WALK_IF;
            defer_cnt_d = '0;
            stale_d     = 1'b0;
            vaddr_d     = bus.if_miss_vaddr;
            is_store_d  = 1'b0;
            is_fetch_d  = 1'b1;
          end else if (ex_elig) begin
            state_d    = WALK_EX;
            stale_d    = 1'b0;
            vaddr_d    = bus.ex_miss_vaddr;
            is_store_d = bus.ex_miss_is_store;
            is_fetch_d = 1'b0;
            // Only a contested EX win counts against the fetch side.
            if (if_elig && defer_cnt_q != CNT_MAX) defer_cnt_d = defer_cnt_q + CNT_W'(1);
          end
        end
      end
      WALK_IF: begin
        if (flush || !bus.translation_enabled) stale_d = 1'b1;
        if (bus.ptw_done) begin
          bus.itlb_update_valid = keep && bus.ptw_result_valid;
          bus.if_walk_done      = keep && bus.if_miss_valid;
          bus.if_walk_fault     = keep && bus.if_miss_valid && bus.ptw_page_fault;
          mask_if_d             = 1'b1;
          state_d               = IDLE;
        end
      end
      WALK_EX: begin
        if (flush || !bus.translation_enabled) stale_d = 1'b1;
        if (bus.ptw_done) begin
          bus.dtlb_update_valid = keep && bus.ptw_result_valid;
          bus.ex_walk_done      = keep && bus.ex_miss_valid;
          bus.ex_walk_fault     = keep && bus.ex_miss_valid && bus.ptw_page_fault;
          mask_ex_d             = 1'b1;
          state_d               = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      defer_cnt_q <= '0;
      stale_q     <= 1'b0;
      mask_if_q   <= 1'b0;
      mask_ex_q   <= 1'b0;
      vaddr_q     <= '0;
      is_store_q  <= 1'b0;
      is_fetch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      defer_cnt_q <= defer_cnt_d;
      stale_q     <= stale_d;
      mask_if_q   <= mask_if_d;
      mask_ex_q   <= mask_ex_d;
      vaddr_q     <= vaddr_d;
      is_store_q  <= is_store_d;
      is_fetch_q  <= is_fetch_d;
    end
  end
endmodule

// File: tb/tb_ptw_walk_arbiter.sv
// Directed bench for ptw_walk_arbiter: expected grants and completions are queued by the stimulus
// and retired by a negedge monitor.
module tb_ptw_walk_arbiter;
  localparam int XLEN = 32;

  typedef struct {
    bit              fetch;
    bit              store;
    logic [XLEN-1:0] va;
  } grant_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  grant_t   grant_q[$];
  bit [5:0] comp_q[$];

  ptw_walk_arbiter_if #(.XLEN(XLEN)) bus ();

  ptw_walk_arbiter #(.XLEN(XLEN), .MAX_IF_DEFER(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit [5:0] mk(bit iu, bit du, bit id, bit ed, bit ifl, bit efl);
    return {iu, du, id, ed, ifl, efl};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.busy) return;
    end
    chk("wait_busy_timeout", 32'(bus.busy), 32'd1);
  endtask

  task automatic pulse_done(input bit rv, input bit pf);
    bus.ptw_done         = 1'b1;
    bus.ptw_result_valid = rv;
    bus.ptw_page_fault   = pf;
    step();
    bus.ptw_done         = 1'b0;
    bus.ptw_result_valid = 1'b0;
    bus.ptw_page_fault   = 1'b0;
  endtask

  task automatic push_grant(input bit fetch, input bit store, input logic [XLEN-1:0] va);
    grant_t g;
    g.fetch = fetch;
    g.store = store;
    g.va    = va;
    grant_q.push_back(g);
  endtask

  // Monitor: retire one expected grant per rising ptw_req_valid, one completion per active pulse.
  initial begin
    bit       prev_req;
    bit [5:0] comp;
    grant_t   g;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ptw_req_valid && !prev_req) begin
        if (grant_q.size() == 0) begin
          chk("unexpected_grant", bus.ptw_req_vaddr, '0);
          if (bus.ptw_req_vaddr === '0) begin
            fails++;
            $display("FAIL unexpected_grant: got grant, expected none");
          end
        end else begin
          g = grant_q.pop_front();
          chk("grant_vaddr", bus.ptw_req_vaddr, g.va);
          chk("grant_fetch", 32'(bus.ptw_req_is_fetch), 32'(g.fetch));
          chk("grant_store", 32'(bus.ptw_req_is_store), 32'(g.store));
        end
      end
      prev_req = bus.ptw_req_valid;
      comp = {bus.itlb_update_valid, bus.dtlb_update_valid, bus.if_walk_done,
              bus.ex_walk_done, bus.if_walk_fault, bus.ex_walk_fault};
      if (comp != 6'b0) begin
        if (comp_q.size() == 0) chk("unexpected_completion", 32'(comp), 32'd0);
        else chk("completion", 32'(comp), 32'(comp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ex_side[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    reset                   = 1'b1;
    bus.if_miss_valid       = 1'b0;
    bus.if_miss_vaddr       = '0;
    bus.ex_miss_valid       = 1'b0;
    bus.ex_miss_vaddr       = '0;
    bus.ex_miss_is_store    = 1'b0;
    bus.translation_enabled = 1'b1;
    bus.tlb_flush_all       = 1'b0;
    bus.tlb_flush_vaddr     = 1'b0;
    bus.ptw_done            = 1'b0;
    bus.ptw_page_fault      = 1'b0;
    bus.ptw_result_valid    = 1'b0;
    repeat (3) step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_req_valid", 32'(bus.ptw_req_valid), 32'd0);
    chk("rst_req_vaddr", bus.ptw_req_vaddr, 32'd0);
    chk("rst_req_fetch", 32'(bus.ptw_req_is_fetch), 32'd0);
    reset = 1'b0;
    step();

    // Single IF miss
    bus.if_miss_valid = 1'b1;
    bus.if_miss_vaddr = 32'h8000_1000;
    push_grant(1'b1, 1'b0, 32'h8000_1000);
    step();
    chk("if_grant_latency", 32'(bus.ptw_req_valid), 32'd1);
    chk("if_req_fetch", 32'(bus.ptw_req_is_fetch), 32'd1);
    repeat (3) step();
    comp_q.push_back(mk(1, 0, 1, 0, 0, 0));
    pulse_done(1'b1, 1'b0);
    bus.if_miss_valid = 1'b0;
    chk("if_busy_after_done", 32'(bus.busy), 32'd0);
    step();

    // Both contending: the fetch side may be passed over at most four times in a row
    bus.if_miss_vaddr = 32'h0000_3000;
    bus.ex_miss_vaddr = 32'h0000_5000;
    for (int k = 0; k < 6; k++) begin
      bus.if_miss_valid = 1'b1;
      bus.ex_miss_valid = 1'b1;
      if (ex_side[k]) begin
        push_grant(1'b0, 1'b0, 32'h0000_5000);
        comp_q.push_back(mk(0, 1, 0, 1, 0, 0));
      end else begin
        push_grant(1'b1, 1'b0, 32'h0000_3000);
        comp_q.push_back(mk(1, 0, 1, 0, 0, 0));
      end
      wait_busy();
      chk("arb_fetch_side", 32'(bus.ptw_req_is_fetch), 32'(!ex_side[k]));
      repeat (2) step();
      pulse_done(1'b1, 1'b0);
      bus.if_miss_valid = 1'b0;
      bus.ex_miss_valid = 1'b0;
      step();
    end

    // EX store page fault
    bus.ex_miss_valid    = 1'b1;
    bus.ex_miss_vaddr    = 32'h4000_2008;
    bus.ex_miss_is_store = 1'b1;
    push_grant(1'b0, 1'b1, 32'h4000_2008);
    wait_busy();
    chk("ex_req_store", 32'(bus.ptw_req_is_store), 32'd1);
    repeat (2) step();
    comp_q.push_back(mk(0, 0, 0, 1, 0, 1));
    pulse_done(1'b0, 1'b1);
    bus.ex_miss_valid    = 1'b0;
    bus.ex_miss_is_store = 1'b0;
    step();

    // Flush mid-walk, then flush in the done cycle, then a clean reissue
    bus.ex_miss_valid = 1'b1;
    bus.ex_miss_vaddr = 32'h0000_7000;
    push_grant(1'b0, 1'b0, 32'h0000_7000);
    wait_busy();
    step();
    bus.tlb_flush_all = 1'b1;
    step();
    bus.tlb_flush_all = 1'b0;
    step();
    pulse_done(1'b1, 1'b0);
    chk("stale_busy", 32'(bus.busy), 32'd0);
    push_grant(1'b0, 1'b0, 32'h0000_7000);
    wait_busy();
    step();
    bus.tlb_flush_vaddr = 1'b1;
    pulse_done(1'b1, 1'b0);
    bus.tlb_flush_vaddr = 1'b0;
    push_grant(1'b0, 1'b0, 32'h0000_7000);
    wait_busy();
    step();
    comp_q.push_back(mk(0, 1, 0, 1, 0, 0));
    pulse_done(1'b1, 1'b0);
    bus.ex_miss_valid = 1'b0;
    step();

    // Translation switched off mid-walk
    bus.ex_miss_valid = 1'b1;
    bus.ex_miss_vaddr = 32'h0000_9000;
    push_grant(1'b0, 1'b0, 32'h0000_9000);
    wait_busy();
    step();
    bus.translation_enabled = 1'b0;
    step();
    pulse_done(1'b1, 1'b0);
    repeat (4) step();
    chk("xlate_off_no_grant", 32'(bus.busy), 32'd0);
    bus.translation_enabled = 1'b1;
    push_grant(1'b0, 1'b0, 32'h0000_9000);
    wait_busy();
    step();
    comp_q.push_back(mk(0, 1, 0, 1, 0, 0));
    pulse_done(1'b1, 1'b0);
    bus.ex_miss_valid = 1'b0;
    step();

    // IF requester abandons its miss mid-walk
    bus.if_miss_valid = 1'b1;
    bus.if_miss_vaddr = 32'h8000_2000;
    push_grant(1'b1, 1'b0, 32'h8000_2000);
    wait_busy();
    step();
    bus.if_miss_valid = 1'b0;
    step();
    comp_q.push_back(mk(1, 0, 0, 0, 0, 0));
    pulse_done(1'b1, 1'b0);
    step();

    // Reset mid-walk, then a late done pulse
    bus.ex_miss_valid = 1'b1;
    bus.ex_miss_vaddr = 32'h0000_b000;
    push_grant(1'b0, 1'b0, 32'h0000_b000);
    wait_busy();
    step();
    reset             = 1'b1;
    bus.ex_miss_valid = 1'b0;
    step();
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_req_valid", 32'(bus.ptw_req_valid), 32'd0);
    chk("midrst_req_vaddr", bus.ptw_req_vaddr, 32'd0);
    chk("midrst_req_store", 32'(bus.ptw_req_is_store), 32'd0);
    reset = 1'b0;
    step();
    pulse_done(1'b1, 1'b0);
    chk("late_done_busy", 32'(bus.busy), 32'd0);

    repeat (3) step();
    chk("grant_q_drained", 32'(grant_q.size()), 32'd0);
    chk("comp_q_drained", 32'(comp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ptw_walk_arbiter.md
# ptw_walk_arbiter

Sequencing arbiter for the shared page-table walker (PTW) in the dual-TLB MMU. Accepts miss requests from the I-TLB side (fetch) and D-TLB side (load/store), grants the single PTW to one of them at a time, and routes the walk result or page fault back to the requesting TLB. Provides D-side priority with bounded I-side starvation, and discards walks invalidated by a TLB flush or by translation being disabled.

## Interface
- XLEN, `XLEN: address/data width (32 Sv32, 64 Sv39)
- MAX_IF_DEFER, 4: consecutive contested D-grants after which I-side wins
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_miss_valid  in  1  I-TLB miss; held until if_walk_done
- if_miss_vaddr  in  XLEN  fetch VA
- ex_miss_valid  in  1  D-TLB miss; held until ex_walk_done
- ex_miss_vaddr  in  XLEN  data VA
- ex_miss_is_store  in  1  store access
- translation_enabled  in  1  satp mode on and not M-mode
- tlb_flush_all, tlb_flush_vaddr  in  1  flush events (any flush marks in-flight walk stale)
- ptw_req_valid  out  1  walk request, held through walk
- ptw_req_vaddr  out  XLEN  latched VA of granted walk
- ptw_req_is_store, ptw_req_is_fetch  out  1  latched access type
- ptw_done  in  1  one-cycle walk completion pulse from PTW
- ptw_page_fault  in  1  valid with ptw_done
- ptw_result_valid  in  1  successful walk, with ptw_done
- itlb_update_valid, dtlb_update_valid  out  1  TLB write enables (PTW vpn/ppn/pte/level fan out directly)
- if_walk_done, ex_walk_done  out  1  one-cycle completion pulse to requester
- if_walk_fault, ex_walk_fault  out  1  page fault, valid with *_walk_done
- busy  out  1  walk in flight

## Operation
- States: IDLE, WALK_IF, WALK_EX.
- IDLE grant, evaluated each cycle, only if translation_enabled: eligible side = miss_valid && !done_mask_side.
  - Only one eligible -> grant it.
  - Both eligible: if if_defer_cnt == MAX_IF_DEFER grant IF, else grant EX and increment if_defer_cnt.
  - Any IF grant clears if_defer_cnt to 0. An uncontested EX grant leaves the counter unchanged.
- On grant: latch vaddr/is_store/is_fetch (is_store forced 0 on IF), clear stale, move to WALK_*.
- WALK_*: ptw_req_valid=1 with latched fields. Set stale on any flush, or when translation_enabled=0.
- Completion (ptw_done=1 in WALK_x):
  - If not stale: x-side update_valid = ptw_result_valid; x_walk_done = 1 only if x_miss_valid is still high; x_walk_fault = ptw_page_fault.
  - If stale, or if a flush occurs in this same cycle: no update, no done, no fault. The requester stays valid and is re-arbitrated.
  - Next state IDLE. Set done_mask for side x for exactly one cycle.
- A requester dropping miss_valid mid-walk (trap/pipeline flush) does not abort the walk. A non-stale result is still written to the TLB, and no done pulse is issued.
- ptw_done outside WALK_* is ignored.

## Timing
- Reset values:
  - Outputs: state IDLE, ptw_req_valid=0, ptw_req_* = 0, busy=0, all update/done/fault = 0.
  - Internal: if_defer_cnt=0, stale=0, done_mask=0.
- Grant latency: a request seen in IDLE at cycle N gives ptw_req_valid=1 at N+1 (registered).
- update_valid, walk_done and walk_fault are combinational in the ptw_done cycle. Return to IDLE at the next edge.
- Back-to-back: the earliest new grant decision is in the first IDLE cycle after completion. That cycle's ptw_req_valid is at +1.
- busy = (state != IDLE). ptw_req_* stable throughout WALK_*.
- Reset mid-walk returns to IDLE. A PTW done pulse after reset is ignored.
- if_defer_cnt width is $clog2(MAX_IF_DEFER+1) and saturates at MAX_IF_DEFER.

## Test plan
- Single IF miss, VA 0x8000_1000, PTW done at +5 with result_valid=1 -> ptw_req_is_fetch=1; itlb_update_valid and if_walk_done pulse in the done cycle; dtlb_update_valid=0; busy back to 0 the next cycle.
- Both misses held continuously, each walk 3 cycles, MAX_IF_DEFER=4 -> grant order EX,EX,EX,EX,IF,EX... IF is never deferred more than 4 contested grants.
- EX store miss at VA 0x4000_2008, done with ptw_page_fault=1 -> ex_walk_fault=1 with ex_walk_done, no dtlb_update_valid, ptw_req_is_store=1.
- tlb_flush_all pulse two cycles into a WALK_EX -> at ptw_done no update and no done. The walk is reissued next IDLE with the same VA, and the second completion reports normally.
- translation_enabled drops mid-walk while ex_miss_valid stays high -> completion discarded, no new grant while it stays low.
- if_miss_valid drops mid-walk -> itlb_update_valid still pulses on completion, if_walk_done stays 0; reset asserted mid-walk -> all outputs 0 next cycle.
